// File: rtl/ram_sp_rwmode.sv
// Single-port synchronous RAM: byte-lane writes, registered read with valid strobe,
// selectable read-during-write mode. Define RAM_CLEAR_EN to build the post-reset clear sequencer.
module ram_sp_rwmode #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32,
  parameter int byteWidth    = 8,
  parameter int rdwMode      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              we,
  input  logic [dataWidth/byteWidth-1:0]    be,
  input  logic [addressWidth-1:0]           address,
  input  logic [dataWidth-1:0]              din,
  input  logic                              clr,
  output logic                              ready,
  output logic [dataWidth-1:0]              dout,
  output logic                              dout_valid,
  output logic [dataWidth-1:0]              mem_0
);

  localparam int NB    = dataWidth / byteWidth;
  localparam int DEPTH = 2 ** addressWidth;

  logic [dataWidth-1:0]    mem [DEPTH];
  logic                    accept;
  logic [dataWidth-1:0]    rd_word;
  logic [dataWidth-1:0]    wr_word;
  logic                    clr_we;
  logic [addressWidth-1:0] clr_addr;

  function automatic logic [dataWidth-1:0] merge_lanes(
    input logic [dataWidth-1:0] old_word,
    input logic [dataWidth-1:0] new_word,
    input logic [NB-1:0]        lane_en
  );
    logic [dataWidth-1:0] w;
    w = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i]) w[i*byteWidth +: byteWidth] = new_word[i*byteWidth +: byteWidth];
    end
    return w;
  endfunction

  assign accept  = en && ready;
  assign rd_word = mem[address];
  assign wr_word = merge_lanes(rd_word, din, be);
  assign mem_0   = mem[0];

`ifdef RAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [addressWidth-1:0] ptr;
  logic [addressWidth-1:0] ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // A clr pulse during a sweep is ignored; the sweep always runs to the last word.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready    = (state == IDLE);
  assign clr_we   = (state == CLEAR) && rst_n;
  assign clr_addr = ptr;
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign ready      = 1'b1;
  assign clr_we     = 1'b0;
  assign clr_addr   = '0;
`endif

  // Storage: no reset on the array; clear sweep and accesses are mutually exclusive via ready.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (accept && we) begin
      mem[address] <= wr_word;
    end
  end

  // Read port: rd_word is the pre-write contents, wr_word the merged post-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (accept) begin
        if (!we) begin
          dout       <= rd_word;
          dout_valid <= 1'b1;
        end else if (rdwMode == 0) begin
          dout       <= wr_word;
          dout_valid <= 1'b1;
        end else if (rdwMode == 1) begin
          dout       <= rd_word;
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_rwmode.sv
// Directed bench for ram_sp_rwmode: three instances (write-first, read-first, no-change)
// share one stimulus stream; clear-sequencer checks follow the RAM_CLEAR_EN build.
module tb_ram_sp_rwmode;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic          clr = 1'b0;
  logic [NB-1:0] be = '0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] din = '0;

  logic          rdy0, rdy1, rdy2;
  logic          dv0, dv1, dv2;
  logic [DW-1:0] dout0, dout1, dout2;
  logic [DW-1:0] m0_0, m0_1, m0_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_sp_rwmode #(.addressWidth(AW), .dataWidth(DW), .byteWidth(8), .rdwMode(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address), .din(din),
    .clr(clr), .ready(rdy0), .dout(dout0), .dout_valid(dv0), .mem_0(m0_0));
  ram_sp_rwmode #(.addressWidth(AW), .dataWidth(DW), .byteWidth(8), .rdwMode(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address), .din(din),
    .clr(clr), .ready(rdy1), .dout(dout1), .dout_valid(dv1), .mem_0(m0_1));
  ram_sp_rwmode #(.addressWidth(AW), .dataWidth(DW), .byteWidth(8), .rdwMode(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address), .din(din),
    .clr(clr), .ready(rdy2), .dout(dout2), .dout_valid(dv2), .mem_0(m0_2));

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access, then sample 1 time unit after the edge that consumes it.
  task automatic step(input logic e, input logic w, input logic [NB-1:0] b,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = e; we = w; be = b; address = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n, output logic seen_vld);
    n = 0;
    seen_vld = 1'b0;
    while (!rdy0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen_vld = seen_vld | dv0 | dv1 | dv2;
    end
  endtask

  initial begin
    int   n;
    logic sv;
    logic [7:0] b8;

    #1 rst_n = 1'b0;
    #11;
    check("rst_dout0", dout0, '0);
    check("rst_dout1", dout1, '0);
    check("rst_dv0", {31'b0, dv0}, 32'd0);
    check("rst_dv2", {31'b0, dv2}, 32'd0);
    rst_n = 1'b1;

`ifdef RAM_CLEAR_EN
    check("rst_ready", {31'b0, rdy0}, 32'd0);
    wait_ready(n, sv);
    check("init_sweep_edges", n, 32'd32);
    check("init_sweep_no_vld", {31'b0, sv}, 32'd0);
    check("init_ready1", {31'b0, rdy1}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, '0, AW'(i), '0);
      check($sformatf("init_rd%0d", i), dout0, 32'h0);
      check($sformatf("init_vld%0d", i), {31'b0, dv0}, 32'd1);
    end
`else
    check("noclr_ready", {31'b0, rdy0}, 32'd1);
    step(1'b1, 1'b1, 4'hF, 5'd0, 32'hCAFEF00D);
    check("noclr_mem0", m0_0, 32'hCAFEF00D);
    clr = 1'b1;
    step(1'b1, 1'b0, '0, 5'd0, '0);
    clr = 1'b0;
    check("noclr_clr_ready", {31'b0, rdy0}, 32'd1);
    check("noclr_rd0", dout0, 32'hCAFEF00D);
    check("noclr_rd0_vld", {31'b0, dv0}, 32'd1);
`endif

    // Known dout baseline for the no-change instance
    step(1'b1, 1'b1, 4'hF, 5'd9, 32'h5A5A5A5A);
    check("wf_first_vld2", {31'b0, dv2}, 32'd0);
    step(1'b1, 1'b0, '0, 5'd9, '0);
    check("base_rd_u0", dout0, 32'h5A5A5A5A);
    check("base_rd_u2", dout2, 32'h5A5A5A5A);

    // Read-during-write sequence on addr 3
    step(1'b1, 1'b1, 4'hF, 5'd3, 32'hAABBCCDD);
    check("w1_u0_dout", dout0, 32'hAABBCCDD);
    check("w1_u2_vld", {31'b0, dv2}, 32'd0);
    check("w1_u2_dout", dout2, 32'h5A5A5A5A);
    step(1'b1, 1'b1, 4'b0101, 5'd3, 32'h11223344);
    check("w2_u0_dout", dout0, 32'hAA22CC44);
    check("w2_u0_vld", {31'b0, dv0}, 32'd1);
    check("w2_u1_dout", dout1, 32'hAABBCCDD);
    check("w2_u1_vld", {31'b0, dv1}, 32'd1);
    check("w2_u2_vld", {31'b0, dv2}, 32'd0);
    check("w2_u2_dout", dout2, 32'h5A5A5A5A);
    step(1'b1, 1'b0, '0, 5'd3, '0);
    check("rd3_u0", dout0, 32'hAA22CC44);
    check("rd3_u1", dout1, 32'hAA22CC44);
    check("rd3_u2", dout2, 32'hAA22CC44);
    check("rd3_u2_vld", {31'b0, dv2}, 32'd1);

    // Idle cycle holds dout and drops valid
    step(1'b0, 1'b0, '0, 5'd0, '0);
    check("idle_vld", {31'b0, dv0}, 32'd0);
    check("idle_hold", dout0, 32'hAA22CC44);

    // be=0 write is a no-op
    step(1'b1, 1'b1, 4'h0, 5'd3, 32'hFFFFFFFF);
    check("be0_u0_dout", dout0, 32'hAA22CC44);
    step(1'b1, 1'b0, '0, 5'd3, '0);
    check("be0_rd", dout1, 32'hAA22CC44);

`ifdef RAM_CLEAR_EN
    // Fill with nonzero data, then runtime clear with reads pending throughout
    for (int i = 0; i < 32; i++) begin
      b8 = 8'(i + 1);
      step(1'b1, 1'b1, 4'hF, AW'(i), {4{b8}});
    end
    check("fill_mem0", m0_0, 32'h01010101);
    clr = 1'b1;
    step(1'b1, 1'b0, '0, 5'd5, '0);
    clr = 1'b0;
    check("clr_edge_accept", dout0, 32'h06060606);
    check("clr_edge_vld", {31'b0, dv0}, 32'd1);
    check("clr_edge_ready", {31'b0, rdy0}, 32'd0);
    step(1'b1, 1'b0, '0, 5'd0, '0);
    check("sweep1_mem0", m0_0, 32'h0);
    check("sweep1_vld", {31'b0, dv0}, 32'd0);
    sv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      clr = (k == 4);
      step(1'b1, 1'b0, '0, 5'd0, '0);
      sv = sv | dv0 | dv1 | dv2;
    end
    clr = 1'b0;
    check("sweep_mid_no_vld", {31'b0, sv}, 32'd0);
    wait_ready(n, sv);
    check("sweep_rest_edges", n, 32'd23);
    check("sweep_rest_no_vld", {31'b0, sv}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, '0, AW'(i), '0);
      check($sformatf("clr_rd%0d", i), dout0, 32'h0);
    end

    // Reset in the middle of a sweep
    step(1'b1, 1'b1, 4'hF, 5'd7, 32'h12345678);
    step(1'b1, 1'b0, '0, 5'd7, '0);
    check("pre_rst_rd", dout1, 32'h12345678);
    clr = 1'b1;
    step(1'b0, 1'b0, '0, 5'd0, '0);
    clr = 1'b0;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0, 5'd0, '0);
    check("pre_rst_ready", {31'b0, rdy0}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout0", dout0, 32'h0);
    check("midrst_dout2", dout2, 32'h0);
    check("midrst_vld", {31'b0, dv0}, 32'd0);
    check("midrst_ready", {31'b0, rdy0}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n, sv);
    check("midrst_sweep_edges", n, 32'd32);
    step(1'b1, 1'b0, '0, 5'd7, '0);
    check("midrst_rd7", dout0, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sp_rwmode.md
# ram_sp_rwmode

Single-port synchronous RAM with a parametrised read-during-write mode, byte-lane write enables, a registered read port with a valid strobe, and an optional post-reset clear sequencer. It supersedes the fixed write-first RAM in the memory library and is the default storage macro for register files and scratch buffers that need deterministic contents after reset.

## Interface
Parameters:
- addressWidth, 5, address bits; depth = 2**addressWidth words
- dataWidth, 32, word width; must be a multiple of byteWidth
- byteWidth, 8, bits per byte lane; lanes NB = dataWidth/byteWidth
- rdwMode, 0, read-during-write: 0 write-first, 1 read-first, 2 no-change

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  access request
- we  input  1  write (1) / read (0) when en
- be  input  NB  byte-lane write enables; bit i covers din[i*byteWidth +: byteWidth]
- address  input  addressWidth  word address
- din  input  dataWidth  write data
- clr  input  1  single-cycle pulse requesting a runtime clear sweep
- ready  output  1  high when accesses are accepted
- dout  output  dataWidth  registered read data
- dout_valid  output  1  dout updated on the preceding edge
- mem_0  output  dataWidth  continuous view of word 0 (debug)

## Operation
- Access accepted on a rising edge when en && ready. Accesses while ready=0 are dropped: no write, dout holds, dout_valid=0.
- Write (we=1): lanes with be[i]=1 take din; lanes with be[i]=0 keep old contents. we=1 with be=0 is a legal no-op write.
- Read (we=0): dout <= mem[address]; dout_valid <= 1.
- Write, rdwMode 0: dout <= merged new word (din on enabled lanes, old data elsewhere); dout_valid <= 1.
- Write, rdwMode 1: dout <= old word before the write; dout_valid <= 1.
- Write, rdwMode 2: dout holds; dout_valid <= 0.
- No accepted access: dout holds, dout_valid <= 0.
- Clear sequencer (states IDLE, CLEAR; counter ptr, addressWidth bits):
  - CLEAR: each edge writes 0 to mem[ptr], ptr <= ptr+1; at ptr = 2**addressWidth-1 writes 0 and moves to IDLE; ptr wraps to 0.
  - IDLE: clr=1 moves to CLEAR with ptr=0.
  - clr during CLEAR is ignored; the sweep does not restart.
  - ready = (state == IDLE).
- Reset (async): dout=0, dout_valid=0, state=CLEAR, ptr=0, ready=0. The memory array is not reset. Reset asserted mid-sweep aborts the sweep; the sweep restarts from address 0 after release.

## Timing
- Read latency 1 cycle: data and dout_valid appear after the edge that accepts the access.
- Full throughput: one access per cycle, any read/write mix.
- Read of an address written on the previous edge returns the new data in all modes.
- Clear duration 2**addressWidth edges. The first edge with rst_n high clears address 0. After edge 2**addressWidth, ready=1 and an access can be accepted on the next edge.
- clr sampled in IDLE: ready drops after that edge. An access presented on that same edge is still accepted.
- mem_0 is combinational from the array and reflects a write or clear right after the edge.

## Configuration
- RAM_CLEAR_EN defined: clear sequencer compiled in as described above.
- RAM_CLEAR_EN undefined: no sequencer. ready is tied 1, and the clr port exists but is ignored. Array contents after reset are undefined. Reset still clears dout and dout_valid, and accesses are accepted from the first edge after release.

## Test plan
- RAM_CLEAR_EN defined, addressWidth=5, release reset -> ready low 32 edges then high. Reading addresses 0..31 returns 0x00000000 with dout_valid=1, one cycle after each request.
- rdwMode=0: write 0xAABBCCDD to addr 3, then write din=0x11223344 with be=4'b0101 to addr 3 -> dout=0xAA22CC44 after the second write; a read of addr 3 returns 0xAA22CC44.
- rdwMode=1, same sequence -> dout=0xAABBCCDD after the second write; a read returns 0xAA22CC44.
- rdwMode=2, same sequence -> dout_valid=0 and dout unchanged after each write; a read returns 0xAA22CC44.
- Fill words with nonzero data, pulse clr, drive en=1 reads during the sweep -> no dout_valid for 32 cycles, ready returns high, all words read 0, and mem_0=0 from the edge after clr.
- Assert rst_n=0 at ptr=10 for 2 cycles -> dout=0, dout_valid=0, ready=0 immediately. After release the sweep takes a full 32 edges before ready rises.
